apb_cmd_master: RTL and testbench
=================================

// Module: apb_cmd_master
// PURPOSE
//  Synthesizable APB3 requester: turns a valid/ready command stream into APB SETUP/ACCESS transfers.
//  Returns one response per command on a valid/ready response stream.
//  Sits between a control engine and apb_slave. Replaces task-driven stimulus with an RTL initiator.
//  One transfer is in flight at a time; there is no command queue.
// PARAMETERS
//  ADDR_W          32  width of cmd_addr / paddr
//  DATA_W          32  width of write/read data
//  TIMEOUT_CYCLES  16  max ACCESS cycles with pready=0 before abort (used only with APB_TIMEOUT_EN)
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  reset        in   1       asynchronous, active-high
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       command accepted when cmd_valid & cmd_ready
//  cmd_write    in   1       1 = write, 0 = read
//  cmd_addr     in   ADDR_W  transfer address, passed through unmodified
//  cmd_wdata    in   DATA_W  write data (ignored for reads)
//  rsp_valid    out  1       response present, held until rsp_ready
//  rsp_ready    in   1       response consumed when rsp_valid & rsp_ready
//  rsp_rdata    out  DATA_W  read data; 0 for writes
//  rsp_err      out  1       pslverr sampled at completion, or timeout abort
//  rsp_timeout  out  1       access aborted by watchdog (constant 0 without APB_TIMEOUT_EN)
//  psel         out  1       APB select
//  penable      out  1       APB enable
//  pwrite       out  1       APB direction
//  paddr        out  ADDR_W  APB address
//  pwdata       out  DATA_W  APB write data
//  prdata       in   DATA_W  APB read data
//  pready       in   1       APB ready; sampled only in ACCESS
//  pslverr      in   1       APB error; sampled only with pready=1 in ACCESS
// BEHAVIOUR
//  Reset values (async, immediate):
//   - state = IDLE.
//   - psel = penable = pwrite = 0; paddr = pwdata = 0.
//   - rsp_valid = rsp_err = rsp_timeout = 0; rsp_rdata = 0.
//   - cmd_ready = 1 once reset is deasserted.
//  All outputs are registered, except cmd_ready = (state == IDLE).
//  FSM:
//   - IDLE:   on cmd_valid, latch write/addr/wdata and go to SETUP. Otherwise stay.
//   - SETUP:  psel=1, penable=0; paddr/pwrite/pwdata stable. Unconditionally go to ACCESS next cycle.
//   - ACCESS: psel=1, penable=1, all controls held.
//             On pready=1: capture rdata = pwrite ? 0 : prdata and err = pslverr; drop psel/penable; go to RESP.
//             On pready=0: stay (wait state). Addr/data/controls do not change.
//   - RESP:   rsp_valid=1; psel=0. On rsp_ready go to IDLE. No new command is accepted in RESP.
//  Latency with zero wait states:
//   - accept at edge T; SETUP visible after T; ACCESS after T+1; rsp_valid after T+2.
//   - Each wait state adds one cycle.
//  Minimum command-to-command spacing is 4 cycles. psel deasserts for >=1 cycle between transfers.
//  rsp_rdata/rsp_err/rsp_timeout are stable while rsp_valid=1 and rsp_ready=0.
//  Reset during SETUP/ACCESS/RESP: transfer abandoned, no response produced, APB bus idle immediately.
//  The latched command is not replayed after reset.
// CONFIGURATION
//  APB_TIMEOUT_EN defined:
//   - ACCESS-cycle counter clears on SETUP entry and increments each ACCESS cycle with pready=0.
//   - When it reaches TIMEOUT_CYCLES: go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//   - psel/penable drop on that edge.
//  APB_TIMEOUT_EN undefined:
//   - No counter; ACCESS waits indefinitely.
//   - rsp_timeout tied 0; TIMEOUT_CYCLES unused.
// STRUCTURE
//  apb_pkg:
//   - apb_state_e enum {IDLE, SETUP, ACCESS, RESP}.
//   - Register offset localparams shared with apb_slave: OPA=0x0, OPB=0x4, CTRL=0x8, RES=0xC.
//  Sub-module apb_timeout_counter (clk, reset, clear, inc, expired). Instantiated only under APB_TIMEOUT_EN.
// TESTING
//  1 Write 0x0 <- 0xAAAAAAAA, pready=1 -> psel 2 cycles, penable 1 cycle; rsp_valid, err=0, rdata=0.
//  2 Read 0x4 with 3 wait states, prdata=0x0F0F0F0F -> penable 4 cycles, controls stable; rsp_rdata=0x0F0F0F0F.
//  3 Against apb_slave: write OPA=0x12345678, OPB=0xFFFFFFFF, CTRL=1; read RES -> 0x12345678, err=0.
//  4 Read 0x10000000, slave pslverr=1 -> rsp_err=1. Hold rsp_ready=0 for 5 cycles: rsp fields stable, cmd_ready=0.
//  5 APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready stuck 0 -> after 16 ACCESS cycles rsp_err=1, rsp_timeout=1, psel=0.
//  6 Assert reset mid-ACCESS -> psel/penable 0 same cycle, no rsp_valid; next command completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state type and register map for the APB requester/slave pair.
// The register offsets must match the apb_slave decoder.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam logic [31:0] OPA  = 32'h0000_0000;
    localparam logic [31:0] OPB  = 32'h0000_0004;
    localparam logic [31:0] CTRL = 32'h0000_0008;
    localparam logic [31:0] RES  = 32'h0000_000C;

endpackage

// File: rtl/apb_timeout_counter.sv
// apb_timeout_counter: counts ACCESS wait cycles and flags the cycle that hits LIMIT.
// Used by apb_cmd_master only when APB_TIMEOUT_EN is defined.
module apb_timeout_counter #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    // Fires on the wait cycle that would make the count reach LIMIT.
    assign expired = inc && (count == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: APB3 requester turning a valid/ready command stream into transfers.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    apb_state_e state;
    logic       start;
    logic       timeout_hit;

    assign start     = (state == IDLE) && cmd_valid;
    assign cmd_ready = (state == IDLE);

`ifdef APB_TIMEOUT_EN
    logic wait_cycle;

    assign wait_cycle = (state == ACCESS) && !pready;

    apb_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (start),
        .inc    (wait_cycle),
        .expired(timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        pwrite  <= cmd_write;
                        paddr   <= cmd_addr;
                        pwdata  <= cmd_wdata;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // A completing pready takes priority over a same-cycle watchdog hit.
                    if (pready) begin
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: randomized self-checking bench with a behavioural APB register slave.
// Timeout scenario is exercised only when APB_TIMEOUT_EN is defined.
module tb_apb_cmd_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int compared = 0;
    int mismatched = 0;

    // Register file of the modelled slave: OPA, OPB, CTRL, RES.
    logic [31:0] regs [4];

    always #5 clk = ~clk;

    apb_cmd_master #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .prdata(prdata),
        .pready(pready),
        .pslverr(pslverr)
    );

    function automatic logic slave_err(input logic [31:0] a);
        return a >= 32'h10;
    endfunction

    function automatic void slave_write(input logic [31:0] a, input logic [31:0] d);
        regs[a[3:2]] = d;
        if (a[3:2] == 2'd2 && d[0])
            regs[3] = regs[0] & regs[1];
    endfunction

    // One full command through the DUT; waits = wait states, hold = rsp_ready=0 cycles.
    task automatic run_cmd(input string tag, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input int waits, input int hold);
        logic        e_err;
        logic [31:0] drv;
        logic [31:0] e_rd;
        e_err = slave_err(a);
        if (w || e_err) drv = $urandom;
        else drv = regs[a[3:2]];
        e_rd = w ? 32'h0 : drv;

        @(negedge clk);
        compared++;
        if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin
            mismatched++;
            $display("FAIL %s idle: rdy/psel/rv=%b%b%b want 100", tag, cmd_ready, psel, rsp_valid);
        end
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;

        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        compared++;
        if ({cmd_ready, psel, penable, pwrite, paddr} !== {1'b0, 1'b1, 1'b0, w, a}
            || (w && pwdata !== d)) begin
            mismatched++;
            $display("FAIL %s setup: rdy=%b psel=%b pen=%b pw=%b pa=%h pd=%h want w=%b a=%h d=%h",
                     tag, cmd_ready, psel, penable, pwrite, paddr, pwdata, w, a, d);
        end

        for (int k = 0; k <= waits; k++) begin
            @(negedge clk);
            compared++;
            if ({psel, penable, pwrite, paddr, rsp_valid} !== {1'b1, 1'b1, w, a, 1'b0}
                || (w && pwdata !== d)) begin
                mismatched++;
                $display("FAIL %s access%0d: psel=%b pen=%b pw=%b pa=%h pd=%h rv=%b want a=%h",
                         tag, k, psel, penable, pwrite, paddr, pwdata, rsp_valid, a);
            end
            if (k == waits) begin
                pready  = 1'b1;
                prdata  = drv;
                pslverr = e_err;
            end else begin
                pready  = 1'b0;
                prdata  = $urandom;
                pslverr = 1'($urandom);
            end
        end

        @(negedge clk);
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'($urandom);
        if (w && !e_err) slave_write(a, d);
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            compared++;
            if ({rsp_valid, psel, penable, cmd_ready, rsp_err, rsp_timeout, rsp_rdata}
                !== {1'b1, 1'b0, 1'b0, 1'b0, e_err, 1'b0, e_rd}) begin
                mismatched++;
                $display("FAIL %s resp%0d: rv=%b psel=%b pen=%b rdy=%b err=%b to=%b rd=%h want err=%b rd=%h",
                         tag, h, rsp_valid, psel, penable, cmd_ready, rsp_err, rsp_timeout,
                         rsp_rdata, e_err, e_rd);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        compared++;
        if ({rsp_valid, cmd_ready, psel} !== 3'b010) begin
            mismatched++;
            $display("FAIL %s done: rv=%b rdy=%b psel=%b want 010", tag, rsp_valid, cmd_ready, psel);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        for (int i = 0; i < 4; i++) regs[i] = '0;
        repeat (2) @(negedge clk);
        compared++;
        if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== '0) begin
            mismatched++;
            $display("FAIL reset_vals: psel=%b pen=%b pw=%b pa=%h pd=%h rv=%b err=%b to=%b rd=%h want all 0",
                     psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        compared++;
        if (cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_ready: cmd_ready=%b want 1", cmd_ready);
        end
    endtask

    task automatic test_directed();
        run_cmd("wr_opa", 1'b1, 32'h0, 32'hAAAA_AAAA, 0, 0);
        run_cmd("wr_opb", 1'b1, 32'h4, 32'h0F0F_0F0F, 0, 0);
        run_cmd("rd_opb_wait3", 1'b0, 32'h4, 32'h0, 3, 1);
    endtask

    task automatic test_slave_op();
        run_cmd("op_opa", 1'b1, 32'h0, 32'h1234_5678, 0, 0);
        run_cmd("op_opb", 1'b1, 32'h4, 32'hFFFF_FFFF, 1, 0);
        run_cmd("op_ctrl", 1'b1, 32'h8, 32'h1, 0, 0);
        run_cmd("op_res", 1'b0, 32'hC, 32'h0, 2, 0);
    endtask

    task automatic test_slverr_hold();
        run_cmd("err_hold5", 1'b0, 32'h1000_0000, 32'h0, 0, 5);
        run_cmd("err_wr", 1'b1, 32'h1000_0040, 32'h5555_5555, 1, 2);
    endtask

    task automatic test_long_wait();
`ifndef APB_TIMEOUT_EN
        run_cmd("long_wait20", 1'b0, 32'h0, 32'h0, 20, 0);
`endif
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 7) == 0) a = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
            else a = {28'h0, 2'($urandom), 2'b00};
            run_cmd("rand", 1'($urandom), a, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'hBAD0_BAD0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        pready = 1'b0;
        compared++;
        if ({psel, penable} !== 2'b11) begin
            mismatched++;
            $display("FAIL rst_mid_pre: psel=%b pen=%b want 11", psel, penable);
        end
        #2 reset = 1'b1;
        #1;
        compared++;
        if ({psel, penable, rsp_valid} !== 3'b000) begin
            mismatched++;
            $display("FAIL rst_mid_async: psel=%b pen=%b rv=%b want 000", psel, penable, rsp_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin
            mismatched++;
            $display("FAIL rst_mid_after: rdy=%b psel=%b rv=%b want 100", cmd_ready, psel, rsp_valid);
        end
        run_cmd("post_rst_rd", 1'b0, 32'h0, 32'h0, 1, 0);
    endtask

    task automatic test_timeout();
`ifdef APB_TIMEOUT_EN
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h4;
        @(negedge clk);
        cmd_valid = 1'b0;
        pready    = 1'b0;
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            prdata = $urandom;
            compared++;
            if ({psel, penable, rsp_valid} !== 3'b110) begin
                mismatched++;
                $display("FAIL timeout_wait%0d: psel=%b pen=%b rv=%b want 110", k, psel, penable, rsp_valid);
            end
        end
        @(negedge clk);
        compared++;
        if ({rsp_valid, psel, penable, rsp_err, rsp_timeout, rsp_rdata} !== {5'b10011, 32'h0}) begin
            mismatched++;
            $display("FAIL timeout_rsp: rv=%b psel=%b pen=%b err=%b to=%b rd=%h want 1 0 0 1 1 0",
                     rsp_valid, psel, penable, rsp_err, rsp_timeout, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        run_cmd("post_timeout", 1'b0, 32'h4, 32'h0, 0, 0);
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_slave_op();
        test_slverr_hold();
        test_long_wait();
        test_random();
        test_reset_mid_access();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
